// File: rtl/non_max_suppression_pkg.sv
// Shared types and constants for the Canny non-maximum suppression stage.
package non_max_suppression_pkg;

  typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} grad_dir_t;

  // tan(22.5 deg) ~= TAN_NUM / 2**TAN_SHIFT
  localparam int TAN_NUM   = 13;
  localparam int TAN_SHIFT = 5;

endpackage

// File: rtl/non_max_suppression_if.sv
// Streaming pixel interface: gradient inputs in, suppressed magnitude out.
interface non_max_suppression_if #(parameter int NBIT = 11);
  logic            i_data_valid;
  logic [NBIT:0]   i_mag;
  logic [NBIT-1:0] i_gx;
  logic [NBIT-1:0] i_gy;
  logic            o_data_valid;
  logic [NBIT:0]   o_nms;
  logic [1:0]      o_dir;
  logic            o_frame_end;

  modport master (
    output i_data_valid, i_mag, i_gx, i_gy,
    input  o_data_valid, o_nms, o_dir, o_frame_end
  );

  modport slave (
    input  i_data_valid, i_mag, i_gx, i_gy,
    output o_data_valid, o_nms, o_dir, o_frame_end
  );
endinterface

// File: rtl/nms_line_buffer.sv
// Line storage: synchronous write, asynchronous read at the same address.
module nms_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 28
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/non_max_suppression.sv
// Canny NMS: quantises gradient direction, builds a 3x3 window from two
// buffered lines and keeps the centre magnitude only at a directional peak.
module non_max_suppression
  import non_max_suppression_pkg::*;
#(
  parameter int NBIT       = 11,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic                  i_clk,
  input logic                  i_rst,
  non_max_suppression_if.slave bus
);

  localparam int MW = NBIT + 1;
  localparam int PW = NBIT + 3;
  localparam int QW = NBIT + 5;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef struct packed {
    grad_dir_t     dir;
    logic [MW-1:0] mag;
  } pix_t;

  logic [NBIT-1:0] ax, ay;
  logic [QW-1:0]   ax_s, ay_s, ax_t, ay_t;
  grad_dir_t       in_dir;
  pix_t            cur;

  always_comb begin
    ax   = bus.i_gx[NBIT-1] ? -bus.i_gx : bus.i_gx;
    ay   = bus.i_gy[NBIT-1] ? -bus.i_gy : bus.i_gy;
    ax_s = QW'(ax) << TAN_SHIFT;
    ay_s = QW'(ay) << TAN_SHIFT;
    ax_t = QW'(ax) * QW'(TAN_NUM);
    ay_t = QW'(ay) * QW'(TAN_NUM);
    if (ay_s <= ax_t)                          in_dir = DIR_0;
    else if (ay_t >= ax_s)                     in_dir = DIR_90;
    else if (bus.i_gx[NBIT-1] == bus.i_gy[NBIT-1]) in_dir = DIR_45;
    else                                       in_dir = DIR_135;
    cur = '{dir: in_dir, mag: bus.i_mag};
  end

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [2*PW-1:0] lb_rdata;
  pix_t            lb_prev1, lb_prev2;

  // Upper half holds row r-2, lower half row r-1; writing shifts both down a line.
  assign lb_prev2 = lb_rdata[2*PW-1:PW];
  assign lb_prev1 = lb_rdata[PW-1:0];

  nms_line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(2 * PW)
  ) u_line_buffer (
    .clk  (i_clk),
    .we   (bus.i_data_valid),
    .addr (col_q),
    .wdata({lb_prev1, cur}),
    .rdata(lb_rdata)
  );

  pix_t [2:0][2:0] win_q, win_d;
  pix_t            centre, nb_a, nb_b;
  logic            emit, border, keep;
  logic            valid_q, valid_d, fe_q, fe_d;
  logic [MW-1:0]   nms_q, nms_d;
  grad_dir_t       dir_q, dir_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (bus.i_data_valid) begin
      for (int unsigned i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb_prev2;
      win_d[1][2] = lb_prev1;
      win_d[2][2] = cur;
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Compare against the freshly shifted window so the result registers one cycle after input.
  always_comb begin
    centre = win_d[1][1];
    nb_a   = win_d[1][0];
    nb_b   = win_d[1][2];
    case (centre.dir)
      DIR_90:  begin nb_a = win_d[0][1]; nb_b = win_d[2][1]; end
      DIR_45:  begin nb_a = win_d[0][0]; nb_b = win_d[2][2]; end
      DIR_135: begin nb_a = win_d[0][2]; nb_b = win_d[2][0]; end
      default: begin nb_a = win_d[1][0]; nb_b = win_d[1][2]; end
    endcase
    keep    = (centre.mag > nb_a.mag) && (centre.mag >= nb_b.mag);
    emit    = bus.i_data_valid && (row_q != '0) && (col_q != '0);
    border  = (row_q == RW'(1)) || (col_q == CW'(1));
    valid_d = emit;
    nms_d   = nms_q;
    dir_d   = dir_q;
    fe_d    = 1'b0;
    if (emit) begin
      nms_d = (keep && !border) ? centre.mag : '0;
      dir_d = centre.dir;
      fe_d  = (row_q == RW'(IMG_HEIGHT - 1)) && (col_q == CW'(IMG_WIDTH - 1));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      nms_q   <= '0;
      dir_q   <= DIR_0;
      fe_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      nms_q   <= nms_d;
      dir_q   <= dir_d;
      fe_q    <= fe_d;
    end
  end

  assign bus.o_data_valid = valid_q;
  assign bus.o_nms        = nms_q;
  assign bus.o_dir        = dir_q;
  assign bus.o_frame_end  = fe_q;

endmodule

// File: tb/tb_non_max_suppression.sv
// Directed bench for non_max_suppression (W=8, H=6) with a scoreboard queue.
module tb_non_max_suppression;

  localparam int NBIT = 11;
  localparam int W    = 8;
  localparam int H    = 6;

  typedef struct {
    int         r;
    int         c;
    logic [11:0] nms;
    logic [1:0]  dir;
    logic        fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  non_max_suppression_if #(.NBIT(NBIT)) bus ();

  non_max_suppression #(
    .NBIT      (NBIT),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int out_cnt = 0;
  int fe_cnt  = 0;
  logic [11:0] last_nms = '0;
  logic [1:0]  last_dir = '0;

  int mg [H][W];
  int gxa[H][W];
  int gya[H][W];
  logic [11:0] got_nms[H][W];
  logic [1:0]  got_dir[H][W];
  logic [11:0] ref_nms[H][W];

  exp_t sb[$];

  function automatic int qdir(input int gx, input int gy);
    int ax, ay;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (ay * 32 <= ax * 13) return 0;
    if (ay * 13 >= ax * 32) return 2;
    if ((gx < 0) == (gy < 0)) return 1;
    return 3;
  endfunction

  function automatic exp_t expect_at(input int r, input int c);
    exp_t e;
    int d, m, a, b;
    d = qdir(gxa[r][c], gya[r][c]);
    m = mg[r][c];
    e.r = r;
    e.c = c;
    e.dir = 2'(d);
    e.fe = (r == H - 2) && (c == W - 2);
    if (r == 0 || c == 0) begin
      e.nms = '0;
    end else begin
      case (d)
        0:       begin a = mg[r][c-1];   b = mg[r][c+1];   end
        2:       begin a = mg[r-1][c];   b = mg[r+1][c];   end
        1:       begin a = mg[r-1][c-1]; b = mg[r+1][c+1]; end
        default: begin a = mg[r-1][c+1]; b = mg[r+1][c-1]; end
      endcase
      e.nms = (m > a && m >= b) ? 12'(m) : 12'd0;
    end
    return e;
  endfunction

  task automatic fill(input int gx, input int gy, input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        mg[r][c]  = base;
        gxa[r][c] = gx;
        gya[r][c] = gy;
      end
  endtask

  task automatic set_col(input int c, input int m);
    for (int r = 0; r < H; r++) mg[r][c] = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_data_valid = 1'b0;
    end
  endtask

  task automatic send(input int first, input int count, input int gap_pct);
    for (int k = first; k < first + count; k++) begin
      int r, c;
      r = k / W;
      c = k % W;
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        bus.i_data_valid = 1'b0;
      end
      @(negedge clk);
      bus.i_data_valid = 1'b1;
      bus.i_mag = 12'(mg[r][c]);
      bus.i_gx  = 11'(gxa[r][c]);
      bus.i_gy  = 11'(gya[r][c]);
      if (r >= 1 && c >= 1) sb.push_back(expect_at(r - 1, c - 1));
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_data_valid === 1'b1) begin
      total++;
      assert (sb.size() != 0) passed++;
      else $error("FAIL unexpected_output observed=valid expected=idle");
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (bus.o_nms === e.nms) passed++;
        else $error("FAIL nms(%0d,%0d) observed=%0d expected=%0d", e.r, e.c, bus.o_nms, e.nms);
        total++;
        assert (bus.o_dir === e.dir) passed++;
        else $error("FAIL dir(%0d,%0d) observed=%0d expected=%0d", e.r, e.c, bus.o_dir, e.dir);
        total++;
        assert (bus.o_frame_end === e.fe) passed++;
        else $error("FAIL frame_end(%0d,%0d) observed=%0b expected=%0b", e.r, e.c, bus.o_frame_end, e.fe);
        got_nms[e.r][e.c] = bus.o_nms;
        got_dir[e.r][e.c] = bus.o_dir;
        last_nms = bus.o_nms;
        last_dir = bus.o_dir;
        out_cnt++;
        if (bus.o_frame_end === 1'b1) fe_cnt++;
      end
    end
  end

  int qgx[5]  = '{100, 100, 100, 0, 0};
  int qgy[5]  = '{40, 41, -100, 5, 0};
  int qexp[5] = '{0, 1, 3, 2, 0};

  initial begin
    bus.i_data_valid = 1'b0;
    bus.i_mag = '0;
    bus.i_gx  = '0;
    bus.i_gy  = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        got_nms[r][c] = 12'hfff;
        got_dir[r][c] = 2'bxx;
      end

    #1;
    check("reset_valid", int'(bus.o_data_valid), 0);
    check("reset_nms",   int'(bus.o_nms), 0);
    check("reset_dir",   int'(bus.o_dir), 0);
    check("reset_fe",    int'(bus.o_frame_end), 0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Quantiser: uniform gradient frames, plateau magnitude
    for (int q = 0; q < 5; q++) begin
      fill(qgx[q], qgy[q], 50);
      send(0, W * H, 0);
      idle(2);
      check($sformatf("quant%0d_dir", q), int'(got_dir[2][2]), qexp[q]);
      check($sformatf("quant%0d_nms", q), int'(got_nms[2][2]), 0);
    end

    // Vertical ridge at column 3
    fill(200, 0, 50);
    set_col(3, 200);
    send(0, W * H, 0);
    idle(2);
    check("ridge_hold_valid", int'(bus.o_data_valid), 0);
    check("ridge_hold_nms", int'(bus.o_nms), int'(last_nms));
    check("ridge_hold_dir", int'(bus.o_dir), int'(last_dir));
    for (int r = 1; r <= 4; r++) check($sformatf("ridge_r%0d_c3", r), int'(got_nms[r][3]), 200);
    check("ridge_r2_c2", int'(got_nms[2][2]), 0);
    check("ridge_r2_c4", int'(got_nms[2][4]), 0);
    check("ridge_r0_c3", int'(got_nms[0][3]), 0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) ref_nms[r][c] = got_nms[r][c];

    // Tie: columns 3 and 4 both peak
    set_col(4, 200);
    send(0, W * H, 0);
    idle(2);
    check("tie_c3", int'(got_nms[2][3]), 200);
    check("tie_c4", int'(got_nms[2][4]), 0);

    // Two frames back to back
    fill(200, 0, 50);
    set_col(3, 200);
    out_cnt = 0;
    fe_cnt  = 0;
    send(0, W * H, 0);
    send(0, W * H, 0);
    idle(2);
    check("b2b_outputs", out_cnt, 2 * (W - 1) * (H - 1));
    check("b2b_frame_ends", fe_cnt, 2);
    check("b2b_col0", int'(got_nms[2][0]), 0);

    // Same ridge with random idle gaps
    send(0, W * H, 30);
    idle(2);
    for (int r = 0; r < H - 1; r++)
      for (int c = 0; c < W - 1; c++)
        check($sformatf("gap_r%0d_c%0d", r, c), int'(got_nms[r][c]), int'(ref_nms[r][c]));

    // Reset in the middle of row 3
    send(0, 3 * W + 3, 0);
    idle(2);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(bus.o_data_valid), 0);
    check("midrst_nms", int'(bus.o_nms), 0);
    check("midrst_fe", int'(bus.o_frame_end), 0);
    check("midrst_queue", sb.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    out_cnt = 0;
    fe_cnt  = 0;
    send(0, W * H, 0);
    idle(3);
    check("restart_outputs", out_cnt, (W - 1) * (H - 1));
    check("restart_frame_end", fe_cnt, 1);
    check("restart_r3_c3", int'(got_nms[3][3]), 200);
    check("final_queue", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
